regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (RegWrite/WriteRegister/WriteData) between two writeback
//   requesters: A = ALU result path, B = load/memory path. Each requester has a 1-entry holding slot
//   and a valid/ready handshake. A round-robin arbiter issues at most one registered write per cycle.
//   Outputs change on posedge clk, so they are stable when the register file writes on negedge clk.
// PARAMETERS
//   ADDR_W   5    register index width (32 registers)
//   DATA_W   32   write data width
// PORTS
//   clk        in   1        system clock; all state updates on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   flush      in   1        synchronous clear of both holding slots (e.g. on exception)
//   a_valid    in   1        requester A offers a write
//   a_ready    out  1        A's slot can accept this cycle
//   a_addr     in   ADDR_W   A destination register
//   a_data     in   DATA_W   A write data
//   b_valid    in   1        requester B offers a write
//   b_ready    out  1        B's slot can accept this cycle
//   b_addr     in   ADDR_W   B destination register
//   b_data     in   DATA_W   B write data
//   rf_we      out  1        to register-file RegWrite
//   rf_addr    out  ADDR_W   to register-file WriteRegister
//   rf_data    out  DATA_W   to register-file WriteData
//   busy       out  1        either holding slot is full
// BEHAVIOUR
//   - Reset (rst_n=0, async): both slots empty, prio=A, rf_we=0, rf_addr=0, rf_data=0, busy=0.
//   - Slot X (A/B) is full_X, holding addr_X and data_X. Accept = X_valid & X_ready at posedge.
//   - Grant (comb., from slot state only): only one slot full -> grant it; both full -> grant the
//     prio side; none full -> no grant.
//   - X_ready = !full_X | grant_X. There is no comb. path from X_valid to X_ready; same-edge
//     drain+refill is allowed.
//   - On posedge with a grant to X: rf_we<=1, rf_addr<=addr_X, rf_data<=data_X; full_X cleared
//     unless refilled the same edge; prio <= the side not granted.
//   - On posedge with no grant: rf_we<=0; rf_addr/rf_data hold their previous values.
//   - Latency: accepted at edge N -> rf_we high from edge N+1 (uncontended); register-file write at
//     the following negedge. If contended, the loser issues at edge N+2. Worst-case wait is 1 cycle.
//   - Arbitration is fair: two continuously full slots alternate A,B,A,B...
//   - A and B writing the same address on consecutive grants: both issue in grant order, so the
//     last-granted value wins. No merging.
//   - flush=1 at posedge: both slots empty, accepts that edge are dropped, rf_we<=0; prio unchanged.
//     flush takes precedence over grant and accept.
//   - Async reset mid-operation: pending writes are discarded; rf_we drops immediately.
//   - busy = full_A | full_B.
// CONFIGURATION
//   ZERO_WRITE_DROP_EN defined:
//     - An accepted write with addr==0 is consumed and its slot clears normally, but rf_we stays 0 for it.
//     - It still counts as a grant and still updates prio.
//   ZERO_WRITE_DROP_EN undefined:
//     - addr==0 writes issue like any other write.
// TESTING
//   1 reset: rst_n=0 mid-stream with both slots full -> rf_we=0, busy=0, a_ready=b_ready=1 immediately.
//   2 single: A writes r5=0xDEADBEEF at edge N -> rf_we=1, rf_addr=5, rf_data=0xDEADBEEF during N+1 only.
//   3 contention: A(r1=0x11), B(r2=0x22) both accepted at edge N, prio=A -> r1 issues at N+1, r2 at N+2.
//   4 fairness: A and B continuously valid for 6 cycles -> grant order A,B,A,B,A,B;
//     a_ready/b_ready alternate.
//   5 flush: B full with r7=0x77 and flush=1 at edge N -> no write of r7 ever issues; b_ready=1 after N.
//   6 zero reg: A writes r0=0xFFFF -> with ZERO_WRITE_DROP_EN, rf_we stays 0 and a_ready returns to 1;
//     without it, rf_we=1, rf_addr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester round-robin arbiter for the register-file write port
// Optional build macro: ZERO_WRITE_DROP_EN (consume writes to register 0 without asserting rf_we)
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              busy
);

    typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

    prio_t             prio, prio_nxt;
    logic              full_a, full_a_nxt;
    logic              full_b, full_b_nxt;
    logic [ADDR_W-1:0] addr_a, addr_a_nxt;
    logic [ADDR_W-1:0] addr_b, addr_b_nxt;
    logic [DATA_W-1:0] data_a, data_a_nxt;
    logic [DATA_W-1:0] data_b, data_b_nxt;
    logic              rf_we_nxt;
    logic [ADDR_W-1:0] rf_addr_nxt;
    logic [DATA_W-1:0] rf_data_nxt;
    logic              grant_a, grant_b;
    logic              accept_a, accept_b;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_we;

    // Grant depends only on slot state, so ready never combinationally follows valid.
    assign grant_a  = full_a & (~full_b | (prio == PRIO_A));
    assign grant_b  = full_b & (~full_a | (prio == PRIO_B));
    assign a_ready  = ~full_a | grant_a;
    assign b_ready  = ~full_b | grant_b;
    assign accept_a = a_valid & a_ready;
    assign accept_b = b_valid & b_ready;
    assign busy     = full_a | full_b;

    assign win_addr = grant_a ? addr_a : addr_b;
    assign win_data = grant_a ? data_a : data_b;
`ifdef ZERO_WRITE_DROP_EN
    assign win_we   = (win_addr != '0);
`else
    assign win_we   = 1'b1;
`endif

    always_comb begin
        prio_nxt    = prio;
        full_a_nxt  = full_a;
        full_b_nxt  = full_b;
        addr_a_nxt  = addr_a;
        addr_b_nxt  = addr_b;
        data_a_nxt  = data_a;
        data_b_nxt  = data_b;
        rf_we_nxt   = 1'b0;
        rf_addr_nxt = rf_addr;
        rf_data_nxt = rf_data;

        if (flush) begin
            full_a_nxt = 1'b0;
            full_b_nxt = 1'b0;
        end else begin
            if (grant_a || grant_b) begin
                rf_we_nxt = win_we;
                prio_nxt  = grant_a ? PRIO_B : PRIO_A;
                // A dropped register-0 write leaves the last issued address/data on the bus.
                if (win_we) begin
                    rf_addr_nxt = win_addr;
                    rf_data_nxt = win_data;
                end
            end
            if (grant_a) full_a_nxt = 1'b0;
            if (grant_b) full_b_nxt = 1'b0;
            if (accept_a) begin
                full_a_nxt = 1'b1;
                addr_a_nxt = a_addr;
                data_a_nxt = a_data;
            end
            if (accept_b) begin
                full_b_nxt = 1'b1;
                addr_b_nxt = b_addr;
                data_b_nxt = b_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= PRIO_A;
            full_a  <= 1'b0;
            full_b  <= 1'b0;
            addr_a  <= '0;
            addr_b  <= '0;
            data_a  <= '0;
            data_b  <= '0;
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            prio    <= prio_nxt;
            full_a  <= full_a_nxt;
            full_b  <= full_b_nxt;
            addr_a  <= addr_a_nxt;
            addr_b  <= addr_b_nxt;
            data_a  <= data_a_nxt;
            data_b  <= data_b_nxt;
            rf_we   <= rf_we_nxt;
            rf_addr <= rf_addr_nxt;
            rf_data <= rf_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        a_valid, a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .rf_we   (rf_we),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        flush   = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    initial begin
        logic acc_a, acc_b;
        int   na, nb;
        clk = 1'b0; rst_n = 1'b0; flush = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_we", rf_we, 0);
        check("rst_addr", rf_addr, 0);
        check("rst_data", rf_data, 0);
        check("rst_busy", busy, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        rst_n = 1'b1;

        // single uncontended write
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        tick();
        a_valid = 1'b0;
        check("single_n_we", rf_we, 0);
        check("single_n_busy", busy, 1);
        tick();
        check("single_we", rf_we, 1);
        check("single_addr", rf_addr, 5);
        check("single_data", rf_data, 32'hDEADBEEF);
        check("single_busy", busy, 0);
        tick();
        check("single_we_off", rf_we, 0);
        check("single_addr_hold", rf_addr, 5);

        // contention, prio = A after reset
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("cont_busy", busy, 1);
        check("cont_a_ready", a_ready, 1);
        check("cont_b_ready", b_ready, 0);
        check("cont_we0", rf_we, 0);
        tick();
        check("cont_we1", rf_we, 1);
        check("cont_addr1", rf_addr, 1);
        check("cont_data1", rf_data, 32'h11);
        check("cont_b_ready1", b_ready, 1);
        tick();
        check("cont_we2", rf_we, 1);
        check("cont_addr2", rf_addr, 2);
        check("cont_data2", rf_data, 32'h22);
        tick();
        check("cont_we3", rf_we, 0);
        check("cont_busy3", busy, 0);

        // fairness: both continuously valid, prio back at A
        na = 0; nb = 0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA0;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hB0;
        for (int c = 0; c < 7; c++) begin
            acc_a = a_ready;
            acc_b = b_ready;
            tick();
            if (acc_a) begin na++; a_data = 32'hA0 + 32'(na); end
            if (acc_b) begin nb++; b_data = 32'hB0 + 32'(nb); end
            if (c >= 1) begin
                int i;
                i = c - 1;
                check($sformatf("fair_we%0d", i), rf_we, 1);
                check($sformatf("fair_addr%0d", i), rf_addr, (i % 2 == 1) ? 4 : 3);
                check($sformatf("fair_data%0d", i), rf_data,
                      (i % 2 == 1) ? (64'hB0 + 64'(i / 2)) : (64'hA0 + 64'(i / 2)));
                check($sformatf("fair_a_ready%0d", i), a_ready, (i % 2 == 1) ? 1 : 0);
                check($sformatf("fair_b_ready%0d", i), b_ready, (i % 2 == 1) ? 0 : 1);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick(); tick(); tick();
        check("fair_drained", busy, 0);

        // flush drops a full slot and a same-edge accept
        do_reset();
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
        tick();
        b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        flush = 1'b1;
        check("flush_pre_busy", busy, 1);
        tick();
        flush = 1'b0; a_valid = 1'b0;
        check("flush_we", rf_we, 0);
        check("flush_busy", busy, 0);
        check("flush_b_ready", b_ready, 1);
        check("flush_a_ready", a_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("flush_no_write%0d", k), rf_we, 0);
        end

        // write to register 0
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF;
        tick();
        a_valid = 1'b0;
        tick();
`ifdef ZERO_WRITE_DROP_EN
        check("zero_we", rf_we, 0);
`else
        check("zero_we", rf_we, 1);
        check("zero_addr", rf_addr, 0);
        check("zero_data", rf_data, 32'hFFFF);
`endif
        check("zero_a_ready", a_ready, 1);
        check("zero_busy", busy, 0);

        // async reset mid-stream with both slots full
        do_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        tick();
        tick();
        check("mid_pre_we", rf_we, 1);
        check("mid_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_a_ready", a_ready, 1);
        check("mid_rst_b_ready", b_ready, 1);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_post_we", rf_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
